cfifo_pmp_sync: RTL and testbench

- Parametrised, clocked successor to the single-stage PMP click FIFO in the MMU path.
- Carries a drive/free token plus a DATA_W payload through DEPTH bubble-pipelined stages.
- Emits a one-cycle fire pulse per stage as the token lands; the per-stage fire pulses trigger PMP check logic at each step.
- Presents the token downstream after a programmable output delay and holds it until downstream returns a free pulse.

---
 rtl/cfifo_pmp_sync.sv | 178 +++++++++++++++++
 tb/tb_cfifo_pmp_sync.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cfifo_pmp_sync.sv
// cfifo_pmp_sync: clocked PMP click FIFO.
// A drive/free token plus payload ripples through DEPTH bubble-pipelined
// stages, pulsing a per-stage fire bit as it lands. The last stage offers
// the token downstream OUT_DELAY cycles after landing and holds it until
// the downstream free pulse arrives.
module cfifo_pmp_sync #(
    parameter int DEPTH     = 1,
    parameter int DATA_W    = 32,
    parameter int OUT_DELAY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_drive,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_ready,
    output logic                       o_free,
    output logic [DEPTH-1:0]           o_fire,
    output logic                       o_driveNext,
    output logic [DATA_W-1:0]          o_data,
    input  logic                       i_freeNext,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_proto_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DLY_W = (OUT_DELAY > 1) ? $clog2(OUT_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(OUT_DELAY - 1);
    localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_OFFER = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Stage storage and registered outputs.
    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_fire;
    logic              r_free;
    logic              r_drive_next;
    logic [CNT_W-1:0]  r_count;
    logic              r_proto_err;
    state_t            r_state;
    logic [DLY_W-1:0]  r_dly;

    // Next-state wires.
    logic              w_consume;
    logic              w_capture;
    logic [DEPTH-1:0]  w_in;
    logic [DEPTH-1:0]  w_out;
    logic [DEPTH-1:0]  w_valid_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_err_now;
    state_t            w_state_nxt;
    logic [DLY_W-1:0]  w_dly_nxt;

    // Downstream may only consume a token that has been offered.
    always_comb begin
        w_consume = i_freeNext && ((r_state == ST_OFFER) || (r_state == ST_HOLD));
        w_capture = i_drive && !r_valid[0];
        w_err_now = (i_drive && r_valid[0]) ||
                    (i_freeNext && !((r_state == ST_OFFER) || (r_state == ST_HOLD)));
    end

    // Bubble rule: a stage fills only if it was empty at the start of the cycle,
    // so a token leaves its stage exactly when the next stage takes it.
    always_comb begin
        w_in        = {DEPTH{1'b0}};
        w_out       = {DEPTH{1'b0}};
        w_count_nxt = {CNT_W{1'b0}};
        w_in[0]     = w_capture;
        for (int k = 1; k < DEPTH; k++) begin
            w_in[k] = r_valid[k-1] && !r_valid[k];
        end
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_out[k] = w_in[k+1];
        end
        w_out[DEPTH-1] = w_consume;
        w_valid_nxt    = (r_valid & ~w_out) | w_in;
        for (int k = 0; k < DEPTH; k++) begin
            w_count_nxt = w_count_nxt + CNT_W'(w_valid_nxt[k]);
        end
    end

    // Output FSM: wait OUT_DELAY after landing, offer once, then hold until freed.
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly;
        case (r_state)
            ST_IDLE: begin
                if (w_in[DEPTH-1]) begin
                    w_state_nxt = ST_WAIT;
                    w_dly_nxt   = DLY_INIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_dly == DLY_ZERO) begin
                    w_state_nxt = ST_OFFER;
                end else begin
                    w_dly_nxt = r_dly - DLY_ONE;
                end
            end
            ST_OFFER: begin
                if (w_consume) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_consume) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_dly_nxt   = DLY_ZERO;
            end
        endcase
    end

    // Control state and registered pulse/level outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= {DEPTH{1'b0}};
            r_fire       <= {DEPTH{1'b0}};
            r_free       <= 1'b0;
            r_drive_next <= 1'b0;
            r_count      <= {CNT_W{1'b0}};
            r_proto_err  <= 1'b0;
            r_state      <= ST_IDLE;
            r_dly        <= DLY_ZERO;
        end else begin
            r_valid      <= w_valid_nxt;
            r_fire       <= w_in;
            r_free       <= r_valid[0] && !w_valid_nxt[0];
            r_drive_next <= (w_state_nxt == ST_OFFER);
            r_count      <= w_count_nxt;
            r_proto_err  <= r_proto_err || w_err_now;
            r_state      <= w_state_nxt;
            r_dly        <= w_dly_nxt;
        end
    end

    // Payload travels with its token; a stage loads only when it captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= {DATA_W{1'b0}};
            end
        end else begin
            if (w_in[0]) begin
                r_data[0] <= i_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_in[k]) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    assign o_ready     = !r_valid[0];
    assign o_free      = r_free;
    assign o_fire      = r_fire;
    assign o_driveNext = r_drive_next;
    assign o_data      = r_data[DEPTH-1];
    assign o_count     = r_count;
    assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_cfifo_pmp_sync.sv
// Bench for cfifo_pmp_sync: a directed DEPTH=1 timing check plus a DEPTH=4
// instance driven with random traffic against a token-level model; payloads
// are checked by a scoreboard monitor on every downstream offer.
module tb_cfifo_pmp_sync;

    localparam int AD  = 4;
    localparam int AOD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT B: DEPTH=1, OUT_DELAY=2 ----------------
    logic        b_rst, b_drive, b_fn, b_ready, b_free, b_dn, b_err;
    logic [31:0] b_data, b_odata;
    logic [0:0]  b_fire;
    logic [0:0]  b_count;

    cfifo_pmp_sync #(.DEPTH(1), .DATA_W(32), .OUT_DELAY(2)) u_b (
        .clk(clk), .rst(b_rst), .i_drive(b_drive), .i_data(b_data),
        .o_ready(b_ready), .o_free(b_free), .o_fire(b_fire),
        .o_driveNext(b_dn), .o_data(b_odata), .i_freeNext(b_fn),
        .o_count(b_count), .o_proto_err(b_err)
    );

    // ---------------- DUT A: DEPTH=4, OUT_DELAY=2 ----------------
    logic          a_rst, a_drive, a_fn, a_ready, a_free, a_dn, a_err;
    logic [31:0]   a_data, a_odata;
    logic [AD-1:0] a_fire;
    logic [2:0]    a_count;

    cfifo_pmp_sync #(.DEPTH(AD), .DATA_W(32), .OUT_DELAY(AOD)) u_a (
        .clk(clk), .rst(a_rst), .i_drive(a_drive), .i_data(a_data),
        .o_ready(a_ready), .o_free(a_free), .o_fire(a_fire),
        .o_driveNext(a_dn), .o_data(a_odata), .i_freeNext(a_fn),
        .o_count(a_count), .o_proto_err(a_err)
    );

    // Token-level model of DUT A: occupancy, payloads, landing time of the
    // token in the last stage, and the expected pulse outputs of this cycle.
    logic [AD-1:0] mv;
    logic [31:0]   md [AD];
    int            land;
    int            ncyc;
    logic [AD-1:0] e_fire;
    logic          e_free, e_dn, e_err;
    logic [31:0]   sbq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return !mv[0];
    endfunction

    function automatic logic m_offerable();
        return mv[AD-1] && (ncyc >= land + AOD);
    endfunction

    // One cycle of DUT A: drive inputs, step the model at the edge, compare.
    task automatic cyc_a(input logic drv, input logic [31:0] dat, input logic fn, input logic rs);
        logic [AD-1:0] nv;
        logic          offerable;
        a_drive = drv; a_data = dat; a_fn = fn; a_rst = rs;
        @(posedge clk);
        e_fire = '0;
        e_free = 1'b0;
        if (rs) begin
            mv    = '0;
            for (int k = 0; k < AD; k++) md[k] = 32'd0;
            e_err = 1'b0;
            sbq.delete();
        end else begin
            offerable = m_offerable();
            if ((drv && mv[0]) || (fn && !offerable)) e_err = 1'b1;
            nv = mv;
            if (fn && offerable) nv[AD-1] = 1'b0;
            for (int k = AD - 2; k >= 0; k--) begin
                if (mv[k] && !mv[k+1]) begin
                    nv[k] = 1'b0; nv[k+1] = 1'b1; md[k+1] = md[k]; e_fire[k+1] = 1'b1;
                end
            end
            if (drv && !mv[0]) begin
                nv[0] = 1'b1; md[0] = dat; e_fire[0] = 1'b1;
                sbq.push_back(dat);
            end
            if (e_fire[AD-1]) land = ncyc + 1;
            e_free = mv[0] && !nv[0];
            mv = nv;
        end
        ncyc++;
        e_dn = mv[AD-1] && (ncyc == land + AOD);
        #1;
        chk("a_ready", a_ready, !mv[0]);
        chk("a_count", a_count, $countones(mv));
        chk("a_fire", a_fire, e_fire);
        chk("a_free", a_free, e_free);
        chk("a_driveNext", a_dn, e_dn);
        chk("a_proto_err", a_err, e_err);
        if (m_offerable()) chk("a_data_hold", a_odata, md[AD-1]);
    endtask

    // Scoreboard monitor: every downstream offer must carry the oldest pending payload.
    always @(negedge clk) begin
        if (a_dn === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=offer required=no_offer (t=%0t)", $time);
            end else begin
                chk("sb_data", a_odata, sbq.pop_front());
            end
        end
    end

    initial begin
        int c;
        int guard;
        b_rst = 1'b1; b_drive = 1'b0; b_fn = 1'b0; b_data = 32'd0;
        a_rst = 1'b1; a_drive = 1'b0; a_fn = 1'b0; a_data = 32'd0;
        mv = '0; land = 0; ncyc = 0; e_fire = '0; e_free = 1'b0; e_dn = 1'b0; e_err = 1'b0;
        for (int k = 0; k < AD; k++) md[k] = 32'd0;

        // ---- DEPTH=1 directed timing ----
        @(posedge clk); #1;
        chk("b_rst_ready", b_ready, 1'b1);
        chk("b_rst_count", b_count, 1'b0);
        chk("b_rst_err", b_err, 1'b0);
        b_rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            b_drive = (n == 2);
            b_data  = (n == 2) ? 32'hA5A5_0001 : $urandom;
            b_fn    = (n == 8);
            @(posedge clk); #1;
            c = n + 1;
            chk("b_fire", b_fire, (c == 3));
            chk("b_driveNext", b_dn, (c == 5));
            chk("b_free", b_free, (c == 9));
            chk("b_ready", b_ready, !(c >= 3 && c <= 8));
            chk("b_count", b_count, (c >= 3 && c <= 8));
            chk("b_err", b_err, 1'b0);
            if (c >= 5 && c <= 8) chk("b_data", b_odata, 32'hA5A5_0001);
        end
        b_drive = 1'b0; b_fn = 1'b0;

        // ---- DEPTH=4: reset state and single-token latency ----
        cyc_a(1'b0, 32'd0, 1'b0, 1'b1);
        cyc_a(1'b1, 32'h1111_0001, 1'b0, 1'b0);
        for (int n = 0; n < 9; n++) cyc_a(1'b0, $urandom, 1'b0, 1'b0);
        cyc_a(1'b0, 32'd0, m_offerable(), 1'b0);
        for (int n = 0; n < 3; n++) cyc_a(1'b0, 32'd0, 1'b0, 1'b0);

        // ---- fill with downstream stalled, then drain in order ----
        for (int n = 0; n < 20; n++) cyc_a(m_ready(), $urandom, 1'b0, 1'b0);
        chk("fill_count", a_count, 3'd4);
        chk("fill_ready", a_ready, 1'b0);
        guard = 0;
        while ((mv != '0) && (guard < 80)) begin
            cyc_a(1'b0, 32'd0, m_offerable() && ($urandom_range(0, 1) == 1), 1'b0);
            guard++;
        end
        chk("drain_count", a_count, 3'd0);

        // ---- protocol errors ----
        cyc_a(1'b0, 32'd0, 1'b1, 1'b0);
        chk("err_free_idle", a_err, 1'b1);
        cyc_a(1'b1, 32'h2222_0002, 1'b0, 1'b0);
        cyc_a(1'b1, 32'h3333_0003, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) cyc_a(1'b0, 32'd0, 1'b0, 1'b0);

        // ---- reset while a token is being offered ----
        guard = 0;
        while (!e_dn && (guard < 40)) begin
            cyc_a(m_ready(), $urandom, 1'b0, 1'b0);
            guard++;
        end
        chk("offer_reached", e_dn, 1'b1);
        cyc_a(1'b1, $urandom, 1'b1, 1'b1);
        chk("mid_rst_count", a_count, 3'd0);
        chk("mid_rst_ready", a_ready, 1'b1);
        chk("mid_rst_err", a_err, 1'b0);
        for (int n = 0; n < 10; n++) cyc_a(1'b0, 32'd0, 1'b0, 1'b0);

        // ---- random legal traffic ----
        for (int n = 0; n < 600; n++) begin
            cyc_a(m_ready() && ($urandom_range(0, 2) != 0), $urandom,
                  m_offerable() && ($urandom_range(0, 1) == 1), 1'b0);
        end
        guard = 0;
        while ((mv != '0) && (guard < 80)) begin
            cyc_a(1'b0, 32'd0, m_offerable(), 1'b0);
            guard++;
        end
        for (int n = 0; n < 2; n++) cyc_a(1'b0, 32'd0, 1'b0, 1'b0);
        chk("final_count", a_count, 3'd0);
        chk("sb_empty", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
